// File: rtl/buzzer_pattern.sv
// buzzer_pattern
// Single-clock buzzer sequencer: a square-wave tone gated into beep /
// silence / gap patterns, with a finite or continuous burst count.
// All timing comes from clock enables derived from clk.
//
// Optional feature macro: BUZZER_PATTERN_ALT_TONE_EN
//   defined   -> beeps alternate TONE_HZ / TONE2_HZ within each burst
//   undefined -> every beep uses TONE_HZ, no secondary divider logic
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   start       single-cycle request, latches the pattern inputs
//   stop        abort to idle (wins over start)
//   on_ticks    tone ticks per beep (0 behaves as 1)
//   off_ticks   silence ticks between beeps of a burst
//   gap_ticks   silence ticks between bursts
//   beeps       beeps per burst (0 = request ignored)
//   bursts      burst count (0 = continuous until stop)
//   busy        high while not idle
//   done        one-cycle pulse on natural completion
//   buzzer_out  registered tone output
//   state_dbg   current FSM state (IDLE=0, TONE=1, SILENT=2, GAP=3)
//
// Handshake: start is a level sampled on each clk edge; it is accepted
// only in idle with beeps!=0 and stop low. There is no backpressure.
module buzzer_pattern #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TONE_HZ  = 2000,
    parameter int TONE2_HZ = 1000,
    parameter int TICK_HZ  = 1000,
    parameter int DUR_W    = 12,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [DUR_W-1:0] on_ticks,
    input  logic [DUR_W-1:0] off_ticks,
    input  logic [DUR_W-1:0] gap_ticks,
    input  logic [CNT_W-1:0] beeps,
    input  logic [CNT_W-1:0] bursts,
    output logic             busy,
    output logic             done,
    output logic             buzzer_out,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, TONE = 2'd1, SILENT = 2'd2, GAP = 2'd3} state_t;

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int HALF     = CLK_HZ / (2 * TONE_HZ);
`ifdef BUZZER_PATTERN_ALT_TONE_EN
    localparam int HALF2    = CLK_HZ / (2 * TONE2_HZ);
    localparam int HALF_MAX = (HALF2 > HALF) ? HALF2 : HALF;
`else
    localparam int HALF_MAX = HALF;
    localparam int unused_tone2_hz = TONE2_HZ;
`endif
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    state_t           state;
    logic [PW-1:0]    presc;
    logic [DUR_W-1:0] dur;
    logic [HW-1:0]    half_cnt;
    logic [DUR_W-1:0] on_l, off_l, gap_l;
    logic [CNT_W-1:0] beeps_l, bursts_l;
    logic [CNT_W-1:0] beep_left, burst_left;
    logic             alt_sel;   // 1 on even-numbered beeps of a burst

    logic             tick;
    logic             expire;
    logic [DUR_W-1:0] lim;
    logic [HW-1:0]    half_last;

    assign state_dbg = state;
    assign tick      = (presc == TICK_LAST);

    always_comb begin
        lim = DUR_W'(1);
        case (state)
            TONE:    lim = (on_l == '0) ? DUR_W'(1) : on_l;
            SILENT:  lim = off_l;
            GAP:     lim = gap_l;
            default: lim = DUR_W'(1);
        endcase
    end

    assign expire = tick && (dur == lim - DUR_W'(1));

`ifdef BUZZER_PATTERN_ALT_TONE_EN
    assign half_last = alt_sel ? HW'(HALF2 - 1) : HW'(HALF - 1);
`else
    logic unused_alt_sel;
    assign unused_alt_sel = alt_sel;
    assign half_last      = HW'(HALF - 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            buzzer_out <= 1'b0;
            presc      <= '0;
            dur        <= '0;
            half_cnt   <= '0;
            on_l       <= '0;
            off_l      <= '0;
            gap_l      <= '0;
            beeps_l    <= '0;
            bursts_l   <= '0;
            beep_left  <= '0;
            burst_left <= '0;
            alt_sel    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state      <= IDLE;
                busy       <= 1'b0;
                buzzer_out <= 1'b0;
                presc      <= '0;
                dur        <= '0;
                half_cnt   <= '0;
                alt_sel    <= 1'b0;
            end else if (state == IDLE) begin
                if (start && beeps != '0) begin
                    on_l       <= on_ticks;
                    off_l      <= off_ticks;
                    gap_l      <= gap_ticks;
                    beeps_l    <= beeps;
                    bursts_l   <= bursts;
                    beep_left  <= beeps;
                    burst_left <= bursts;
                    alt_sel    <= 1'b0;
                    state      <= TONE;
                    busy       <= 1'b1;
                    buzzer_out <= 1'b1;
                    half_cnt   <= '0;
                    presc      <= '0;
                    dur        <= '0;
                end
            end else if (expire) begin
                presc <= '0;
                dur   <= '0;
                if (state == TONE) begin
                    if (beep_left > CNT_W'(1)) begin
                        beep_left <= beep_left - CNT_W'(1);
                        alt_sel   <= ~alt_sel;
                        if (off_l == '0) begin
                            // Back-to-back beeps: tone keeps running, phase not reset.
                            if (half_cnt >= half_last) begin
                                half_cnt   <= '0;
                                buzzer_out <= ~buzzer_out;
                            end else begin
                                half_cnt <= half_cnt + HW'(1);
                            end
                        end else begin
                            state      <= SILENT;
                            buzzer_out <= 1'b0;
                        end
                    end else if (bursts_l == '0 || burst_left > CNT_W'(1)) begin
                        // Continuous mode leaves burst_left untouched forever.
                        if (bursts_l != '0) begin
                            burst_left <= burst_left - CNT_W'(1);
                        end
                        beep_left <= beeps_l;
                        alt_sel   <= 1'b0;
                        if (gap_l == '0) begin
                            state      <= TONE;
                            buzzer_out <= 1'b1;
                            half_cnt   <= '0;
                        end else begin
                            state      <= GAP;
                            buzzer_out <= 1'b0;
                        end
                    end else begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        buzzer_out <= 1'b0;
                        half_cnt   <= '0;
                    end
                end else begin
                    // SILENT or GAP finished: fresh tone entry.
                    state      <= TONE;
                    buzzer_out <= 1'b1;
                    half_cnt   <= '0;
                end
            end else begin
                if (tick) begin
                    presc <= '0;
                    dur   <= dur + DUR_W'(1);
                end else begin
                    presc <= presc + PW'(1);
                end
                if (state == TONE) begin
                    if (half_cnt >= half_last) begin
                        half_cnt   <= '0;
                        buzzer_out <= ~buzzer_out;
                    end else begin
                        half_cnt <= half_cnt + HW'(1);
                    end
                end
            end
        end
    end

endmodule
